// File: rtl/alu_op_sequencer.sv
// Valid/ready front end for the 16-bit ALU: maps opcodes to control lines and repeats shift/rotate/INC/DEC passes.
// Accept at edge T, N passes in T+1..T+N, response held from T+N+1 until rsp_ready; req_ready only in IDLE.
module alu_op_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [CNT_W-1:0] req_cnt,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cflag,
    output logic             rsp_err,
    output logic [5:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               err_q, err_d;
    logic               first_q, first_d;
    logic               upd_c_q, upd_c_d;

    function automatic logic [5:0] op_ctrl(input logic [3:0] op);
        case (op)
            4'h0:    op_ctrl = 6'h00;
            4'h1:    op_ctrl = 6'h12;
            4'h2:    op_ctrl = 6'h22;
            4'h3:    op_ctrl = 6'h18;
            4'h4:    op_ctrl = 6'h14;
            4'h5:    op_ctrl = 6'h1C;
            4'h6:    op_ctrl = 6'h0C;
            4'h7:    op_ctrl = 6'h36;
            4'h8:    op_ctrl = 6'h06;
            4'h9:    op_ctrl = 6'h09;
            4'hA:    op_ctrl = 6'h01;
            4'hB:    op_ctrl = 6'h11;
            4'hC:    op_ctrl = 6'h0D;
            4'hD:    op_ctrl = 6'h05;
            4'hE:    op_ctrl = 6'h15;
            default: op_ctrl = 6'h00;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        err_d    = err_q;
        first_d  = first_q;
        upd_c_d  = upd_c_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    first_d = 1'b1;
                    err_d   = 1'b0;
                    if (req_op == 4'hF) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = S_RESP;
                    end else begin
                        a_d     = req_a;
                        b_d     = req_b;
                        ctrl_d  = op_ctrl(req_op);
                        cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                        upd_c_d = 1'b1;
                        // Repeatable ops with a zero count degrade to one MOV pass that leaves carry alone.
                        if (req_op >= 4'h7) begin
                            if (req_cnt == '0) begin
                                ctrl_d  = 6'h00;
                                upd_c_d = 1'b0;
                            end else begin
                                cnt_d = req_cnt;
                            end
                        end
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                result_d = alu_result;
                if (upd_c_q) begin
                    carry_d = alu_cout;
                end
                cnt_d   = cnt_q - 1'b1;
                first_d = 1'b0;
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
            first_q  <= 1'b0;
            upd_c_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
            first_q  <= first_d;
            upd_c_q  <= upd_c_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_result = result_q;
    assign rsp_cflag  = carry_q;
    assign rsp_err    = err_q;
    // Pass 1 works on the latched operand; later passes feed back the previous result.
    assign alu_ctrl   = (state_q == S_RUN) ? ctrl_q : 6'h00;
    assign alu_a      = (state_q == S_RUN) ? (first_q ? a_q : result_q) : '0;
    assign alu_b      = (state_q == S_RUN) ? b_q : '0;
    assign alu_cin    = carry_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU stub plus an opcode-level model checked every cycle.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [3:0]  req_cnt;
    logic [15:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_cflag, rsp_err;
    logic [5:0]  alu_ctrl;
    logic [15:0] alu_a, alu_b;
    logic        alu_cin;
    logic [15:0] alu_result;
    logic        alu_cout;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic        chk_en = 1'b0;
    logic        carry_m;
    logic        exp_ready, exp_busy, exp_cin, exp_rv, exp_cf, exp_err;
    logic [5:0]  exp_ctrl;
    logic [15:0] exp_a, exp_b, exp_res;

    logic [5:0] ctab [16] = '{6'h00, 6'h12, 6'h22, 6'h18, 6'h14, 6'h1C, 6'h0C, 6'h36,
                              6'h06, 6'h09, 6'h01, 6'h11, 6'h0D, 6'h05, 6'h15, 6'h00};

    alu_op_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_cnt(req_cnt),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cflag(rsp_cflag), .rsp_err(rsp_err),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout), .busy(busy)
    );

    always #5 clk = ~clk;

    // One step of an opcode on value x, returned as {carry, result}.
    function automatic logic [16:0] op_step(input logic [3:0] op, input logic [15:0] x, input logic [15:0] b);
        case (op)
            4'h0: op_step = {1'b0, x};
            4'h1: op_step = {1'b0, x} + {1'b0, b};
            4'h2: op_step = {1'b0, x} + {1'b0, ~b} + 17'd1;
            4'h3: op_step = {1'b0, x & b};
            4'h4: op_step = {1'b0, x | b};
            4'h5: op_step = {1'b0, x ^ b};
            4'h6: op_step = {1'b0, ~x};
            4'h7: op_step = {1'b0, x} + 17'd1;
            4'h8: op_step = {1'b0, x} - 17'd1;
            4'h9, 4'hA: op_step = {x[15], x[14:0], 1'b0};
            4'hB: op_step = {x[15], x[14:0], x[15]};
            4'hC: op_step = {x[0], x[15], x[15:1]};
            4'hD: op_step = {x[0], 1'b0, x[15:1]};
            4'hE: op_step = {x[0], x[0], x[15:1]};
            default: op_step = {1'b0, 16'hDEAD};
        endcase
    endfunction

    // ALU stub: recognises a control word and performs the matching operation.
    always_comb begin
        {alu_cout, alu_result} = {1'b0, 16'hDEAD};
        for (int i = 0; i < 15; i++) begin
            if (ctab[i] == alu_ctrl) {alu_cout, alu_result} = op_step(i[3:0], alu_a, alu_b);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", req_ready, exp_ready);
            chk("busy", busy, exp_busy);
            chk("alu_ctrl", alu_ctrl, exp_ctrl);
            chk("alu_a", alu_a, exp_a);
            chk("alu_b", alu_b, exp_b);
            chk("alu_cin", alu_cin, exp_cin);
            chk("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                chk("rsp_result", rsp_result, exp_res);
                chk("rsp_cflag", rsp_cflag, exp_cf);
                chk("rsp_err", rsp_err, exp_err);
            end
        end
    end

    task automatic set_idle();
        exp_ready = 1'b1; exp_busy = 1'b0; exp_ctrl = 6'h00;
        exp_a = 16'h0; exp_b = 16'h0; exp_cin = carry_m; exp_rv = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst req_ready", req_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_result", rsp_result, 0);
        chk("rst rsp_cflag", rsp_cflag, 0);
        chk("rst rsp_err", rsp_err, 0);
        chk("rst alu_ctrl", alu_ctrl, 0);
        chk("rst alu_a", alu_a, 0);
        chk("rst alu_b", alu_b, 0);
        chk("rst alu_cin", alu_cin, 0);
    endtask

    // Called just after a rising edge with the DUT idle.
    task automatic do_req(input logic [3:0] op, input logic [3:0] cnt, input logic [15:0] a,
                          input logic [15:0] b, input int hold, input logic [15:0] lit_res,
                          input int lit_passes);
        int          n;
        logic        err, upd;
        logic [3:0]  sop;
        logic [15:0] x;
        logic [16:0] r;
        err = (op == 4'hF);
        upd = !(op >= 4'h7 && cnt == 4'h0);
        sop = upd ? op : 4'h0;
        if (err) n = 0;
        else if (op <= 4'h6) n = 1;
        else n = (cnt == 4'h0) ? 1 : int'(cnt);
        chk("model passes", n, lit_passes);
        set_idle();
        req_valid = 1'b1; req_op = op; req_cnt = cnt; req_a = a; req_b = b;
        @(posedge clk); #1;
        // Keep a distractor request pending while busy; it must be ignored.
        req_op = 4'hF; req_a = 16'hBEEF;
        x = a;
        for (int i = 0; i < n; i++) begin
            exp_ready = 1'b0; exp_busy = 1'b1; exp_ctrl = ctab[sop];
            exp_a = x; exp_b = b; exp_cin = carry_m; exp_rv = 1'b0;
            r = op_step(sop, x, b);
            x = r[15:0];
            if (upd) carry_m = r[16];
            @(posedge clk); #1;
        end
        exp_ready = 1'b0; exp_busy = 1'b1; exp_ctrl = 6'h00; exp_a = 16'h0; exp_b = 16'h0;
        exp_cin = carry_m; exp_rv = 1'b1; exp_res = err ? 16'h0 : x; exp_cf = carry_m; exp_err = err;
        chk("literal result", rsp_result, lit_res);
        rsp_ready = 1'b0;
        repeat (hold) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b0;
        set_idle();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_cnt = 4'h0;
        req_a = 16'h0; req_b = 16'h0; rsp_ready = 1'b0; carry_m = 1'b0;
        #2 chk_reset_vals();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; set_idle(); chk_en = 1'b1;
        @(posedge clk); #1;

        do_req(4'h1, 4'h0, 16'h00FF, 16'h0001, 0, 16'h0100, 1);
        do_req(4'hA, 4'h3, 16'h0001, 16'h0000, 0, 16'h0008, 3);
        do_req(4'h1, 4'h0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1);
        chk("carry after wrap", rsp_cflag, 1);
        do_req(4'h8, 4'h0, 16'h1234, 16'h0000, 0, 16'h1234, 1);
        chk("carry kept by MOV pass", rsp_cflag, 1);
        do_req(4'hF, 4'h2, 16'h5555, 16'h3333, 5, 16'h0000, 0);
        do_req(4'h2, 4'h0, 16'h0005, 16'h0007, 0, 16'hFFFE, 1);
        do_req(4'h3, 4'h9, 16'hF0F0, 16'h3C3C, 1, 16'h3030, 1);
        do_req(4'h4, 4'h0, 16'hF0F0, 16'h0F00, 0, 16'hFFF0, 1);
        do_req(4'h5, 4'h0, 16'hAAAA, 16'hFFFF, 0, 16'h5555, 1);
        do_req(4'h6, 4'h0, 16'h00FF, 16'h0000, 0, 16'hFF00, 1);
        do_req(4'h0, 4'h7, 16'h1357, 16'h2468, 0, 16'h1357, 1);
        do_req(4'h7, 4'hF, 16'hFFF0, 16'h0000, 2, 16'hFFFF, 15);
        do_req(4'h8, 4'h2, 16'h0001, 16'h0000, 0, 16'hFFFF, 2);
        do_req(4'h9, 4'h1, 16'h4001, 16'h0000, 0, 16'h8002, 1);
        do_req(4'hB, 4'h4, 16'h8001, 16'h0000, 0, 16'h0018, 4);
        do_req(4'hC, 4'h3, 16'h8000, 16'h0000, 0, 16'hF000, 3);
        do_req(4'hD, 4'h1, 16'h8000, 16'h0000, 0, 16'h4000, 1);
        do_req(4'hE, 4'hF, 16'h0001, 16'h0000, 0, 16'h0002, 15);
        do_req(4'h7, 4'h0, 16'h00AB, 16'h0000, 0, 16'h00AB, 1);

        // Reset during pass 2 of ROR x4.
        set_idle();
        req_valid = 1'b1; req_op = 4'hE; req_cnt = 4'h4; req_a = 16'h0001; req_b = 16'h0000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_ready = 1'b0; exp_busy = 1'b1; exp_ctrl = 6'h15; exp_a = 16'h0001; exp_b = 16'h0;
        exp_cin = carry_m; exp_rv = 1'b0;
        @(posedge clk); #1;
        chk("pass2 alu_ctrl", alu_ctrl, 6'h15);
        chk("pass2 alu_a", alu_a, 16'h8000);
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_vals();
        carry_m = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("no rsp during rst", rsp_valid, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; set_idle(); chk_en = 1'b1;
        @(posedge clk); #1;
        do_req(4'h1, 4'h0, 16'h1000, 16'h0234, 0, 16'h1234, 1);
        chk("carry after reset op", rsp_cflag, 0);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
